// File: rtl/vending_fsm_param.sv
// Parametrised vending controller: product select, quantity, payment, change,
// per-product stock, cancel/refund and an inactivity auto-cancel.
module vending_fsm_param #(
    parameter int unsigned NUM_PROD = 5,
    parameter int unsigned AMT_W = 8,
    parameter logic [NUM_PROD*AMT_W-1:0] PRICE_TABLE = {8'd6, 8'd10, 8'd5, 8'd2, 8'd1},
    parameter int unsigned MAX_QTY = 3,
    parameter int unsigned STOCK_INIT = 4,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic [AMT_W-1:0] display_value,
    output logic [2:0]       state_code,
    output logic             vend,
    output logic [2:0]       vend_prod,
    output logic [2:0]       vend_qty,
    output logic [AMT_W-1:0] change,
    output logic             error
);

    localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SELECT   = 3'd1;
    localparam logic [2:0] S_PRICE    = 3'd2;
    localparam logic [2:0] S_QTY      = 3'd3;
    localparam logic [2:0] S_CONFIRM  = 3'd4;
    localparam logic [2:0] S_PAY      = 3'd5;
    localparam logic [2:0] S_DISPENSE = 3'd6;

    localparam logic [3:0] K_COIN1   = 4'h8;
    localparam logic [3:0] K_COIN5   = 4'h9;
    localparam logic [3:0] K_COIN10  = 4'hA;
    localparam logic [3:0] K_QTY_UP  = 4'hB;
    localparam logic [3:0] K_QTY_DN  = 4'hC;
    localparam logic [3:0] K_CANCEL  = 4'hD;
    localparam logic [3:0] K_CONFIRM = 4'hE;
    localparam logic [3:0] K_OK      = 4'hF;

    logic [2:0]       state, state_nxt;
    logic [2:0]       prod, prod_nxt;
    logic [2:0]       qty, qty_nxt;
    logic [AMT_W-1:0] total, total_nxt;
    logic [AMT_W-1:0] amount, amount_nxt;
    logic [AMT_W-1:0] change_nxt, display_nxt;
    logic             vend_nxt, error_nxt;
    logic [2:0]       vend_prod_nxt, vend_qty_nxt;
    logic [TO_W-1:0]  tcnt, tcnt_nxt;
    logic [3:0]       stock [8];
    logic [3:0]       stock_nxt [8];
    logic [AMT_W-1:0] price_arr [8];

    logic             timed, key_is_prod;
    logic [2:0]       key_prod;
    logic [3:0]       qty_lim;
    logic [AMT_W:0]   coin, coin_sum;

    // Product-indexed price lookup; slots outside 1..NUM_PROD read as zero
    for (genvar g = 0; g < 8; g++) begin : g_price
        if (g >= 1 && g <= NUM_PROD) begin : g_used
            assign price_arr[g] = PRICE_TABLE[(g-1)*AMT_W +: AMT_W];
        end else begin : g_unused
            assign price_arr[g] = '0;
        end
    end

    assign state_code  = state;
    assign timed       = (state == S_QTY) || (state == S_CONFIRM) || (state == S_PAY);
    assign key_prod    = key_code[2:0];
    assign key_is_prod = !key_code[3] && (key_prod != 3'd0) && (key_prod <= 3'(NUM_PROD));
    assign qty_lim     = (stock[prod] < 4'(MAX_QTY)) ? stock[prod] : 4'(MAX_QTY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            prod          <= '0;
            qty           <= '0;
            total         <= '0;
            amount        <= '0;
            change        <= '0;
            display_value <= '0;
            vend          <= 1'b0;
            vend_prod     <= '0;
            vend_qty      <= '0;
            error         <= 1'b0;
            tcnt          <= '0;
            for (int i = 0; i < 8; i++) stock[i] <= 4'(STOCK_INIT);
        end else begin
            state         <= state_nxt;
            prod          <= prod_nxt;
            qty           <= qty_nxt;
            total         <= total_nxt;
            amount        <= amount_nxt;
            change        <= change_nxt;
            display_value <= display_nxt;
            vend          <= vend_nxt;
            vend_prod     <= vend_prod_nxt;
            vend_qty      <= vend_qty_nxt;
            error         <= error_nxt;
            tcnt          <= tcnt_nxt;
            for (int i = 0; i < 8; i++) stock[i] <= stock_nxt[i];
        end
    end

    always_comb begin
        state_nxt     = state;
        prod_nxt      = prod;
        qty_nxt       = qty;
        total_nxt     = total;
        amount_nxt    = amount;
        change_nxt    = change;
        vend_nxt      = 1'b0;
        vend_prod_nxt = vend_prod;
        vend_qty_nxt  = vend_qty;
        error_nxt     = 1'b0;
        tcnt_nxt      = timed ? tcnt + TO_W'(1) : '0;
        for (int i = 0; i < 8; i++) stock_nxt[i] = stock[i];

        coin = '0;
        case (key_code)
            K_COIN1:  coin = (AMT_W+1)'(1);
            K_COIN5:  coin = (AMT_W+1)'(5);
            K_COIN10: coin = (AMT_W+1)'(10);
            default:  coin = '0;
        endcase
        coin_sum = {1'b0, amount} + coin;

        if (key_valid) begin
            tcnt_nxt = '0;
            case (state)
                S_IDLE: begin
                    if (key_code == K_OK) begin
                        state_nxt  = S_SELECT;
                        change_nxt = '0;
                    end else begin
                        error_nxt = 1'b1;
                    end
                end
                S_SELECT: begin
                    if (key_code == K_CANCEL) begin
                        state_nxt = S_IDLE;
                    end else if (key_is_prod && stock[key_prod] != 4'd0) begin
                        prod_nxt  = key_prod;
                        qty_nxt   = 3'd1;
                        state_nxt = S_PRICE;
                    end else begin
                        error_nxt = 1'b1;
                    end
                end
                S_PRICE: begin
                    if (key_code == K_OK)          state_nxt = S_QTY;
                    else if (key_code == K_CANCEL) state_nxt = S_IDLE;
                    else                           error_nxt = 1'b1;
                end
                S_QTY: begin
                    if (key_code == K_QTY_UP) begin
                        if ({1'b0, qty} < qty_lim) qty_nxt = qty + 3'd1;
                        else                       error_nxt = 1'b1;
                    end else if (key_code == K_QTY_DN) begin
                        if (qty > 3'd1) qty_nxt = qty - 3'd1;
                        else            error_nxt = 1'b1;
                    end else if (key_code == K_OK) begin
                        total_nxt = AMT_W'(price_arr[prod] * AMT_W'(qty));
                        state_nxt = S_CONFIRM;
                    end else if (key_code == K_CANCEL) begin
                        state_nxt = S_IDLE;
                    end else begin
                        error_nxt = 1'b1;
                    end
                end
                S_CONFIRM: begin
                    if (key_code == K_CONFIRM)     state_nxt = S_PAY;
                    else if (key_code == K_CANCEL) state_nxt = S_IDLE;
                    else                           error_nxt = 1'b1;
                end
                S_PAY: begin
                    if (coin != '0) begin
                        // Coins that would wrap the amount register are refused
                        if (coin_sum[AMT_W]) error_nxt = 1'b1;
                        else                 amount_nxt = coin_sum[AMT_W-1:0];
                    end else if (key_code == K_OK) begin
                        if (amount >= total) begin
                            state_nxt        = S_DISPENSE;
                            vend_nxt         = 1'b1;
                            vend_prod_nxt    = prod;
                            vend_qty_nxt     = qty;
                            stock_nxt[prod]  = stock[prod] - 4'(qty);
                            change_nxt       = amount - total;
                            amount_nxt       = '0;
                        end else begin
                            error_nxt = 1'b1;
                        end
                    end else if (key_code == K_CANCEL) begin
                        state_nxt  = S_IDLE;
                        change_nxt = amount;
                        amount_nxt = '0;
                    end else begin
                        error_nxt = 1'b1;
                    end
                end
                S_DISPENSE: begin
                    if (key_code == K_CANCEL) state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end else if (TIMEOUT != 0 && timed && tcnt == TO_W'(TIMEOUT - 1)) begin
            // Inactivity behaves like a cancel press; PAY refunds the inserted amount
            state_nxt = S_IDLE;
            if (state == S_PAY) begin
                change_nxt = amount;
                amount_nxt = '0;
            end
        end

        if (state_nxt != state) tcnt_nxt = '0;

        case (state_nxt)
            S_PRICE:    display_nxt = price_arr[prod_nxt];
            S_QTY:      display_nxt = AMT_W'(qty_nxt);
            S_CONFIRM:  display_nxt = total_nxt;
            S_PAY:      display_nxt = amount_nxt;
            S_DISPENSE: display_nxt = change_nxt;
            default:    display_nxt = '0;
        endcase
    end

endmodule

// File: tb/tb_vending_fsm_param.sv
// Bench for vending_fsm_param: table of key presses with expected outputs via a
// scoreboard queue, plus a narrow-amount instance for overflow and async reset.
module tb_vending_fsm_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, key_valid;
    logic [3:0] key_code;
    logic [7:0] display_value, change;
    logic [2:0] state_code, vend_prod, vend_qty;
    logic       vend, error;

    logic       rst4_n, k4_valid;
    logic [3:0] k4_code;
    logic [3:0] disp4, chg4;
    logic [2:0] st4, vp4, vq4;
    logic       vend4, err4;

    vending_fsm_param #(
        .NUM_PROD(5), .AMT_W(8),
        .PRICE_TABLE({8'd6, 8'd10, 8'd5, 8'd2, 8'd1}),
        .MAX_QTY(3), .STOCK_INIT(4), .TIMEOUT(20)
    ) dut (
        .clk(clk), .reset(rst_n), .key_valid(key_valid), .key_code(key_code),
        .display_value(display_value), .state_code(state_code), .vend(vend),
        .vend_prod(vend_prod), .vend_qty(vend_qty), .change(change), .error(error)
    );

    vending_fsm_param #(
        .NUM_PROD(5), .AMT_W(4),
        .PRICE_TABLE({4'd6, 4'd10, 4'd5, 4'd2, 4'd1}),
        .MAX_QTY(3), .STOCK_INIT(4), .TIMEOUT(0)
    ) dut4 (
        .clk(clk), .reset(rst4_n), .key_valid(k4_valid), .key_code(k4_code),
        .display_value(disp4), .state_code(st4), .vend(vend4),
        .vend_prod(vp4), .vend_qty(vq4), .change(chg4), .error(err4)
    );

    typedef struct {
        logic       valid;
        logic [3:0] key;
        logic [2:0] st;
        logic [7:0] disp;
        logic [7:0] chg;
        logic       vend;
        logic [2:0] vprod;
        logic [2:0] vqty;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic k(input logic [3:0] key, input logic [2:0] st, input logic [7:0] disp,
                     input logic [7:0] chg, input logic err);
        vec_t v;
        v = '{1'b1, key, st, disp, chg, 1'b0, 3'd0, 3'd0, err};
        vecs.push_back(v);
    endtask

    task automatic kv(input logic [3:0] key, input logic [7:0] disp, input logic [7:0] chg,
                      input logic [2:0] vp, input logic [2:0] vq);
        vec_t v;
        v = '{1'b1, key, 3'd6, disp, chg, 1'b1, vp, vq, 1'b0};
        vecs.push_back(v);
    endtask

    task automatic idl(input int n, input logic [2:0] st, input logic [7:0] disp,
                       input logic [7:0] chg);
        vec_t v;
        v = '{1'b0, 4'h0, st, disp, chg, 1'b0, 3'd0, 3'd0, 1'b0};
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic build_table();
        // Basic purchase: product 2, one unit, pay 10, ignored key in DISPENSE
        k(4'hF,1,0,0,0); k(4'h2,2,2,0,0); k(4'hF,3,1,0,0); k(4'hF,4,2,0,0); k(4'hE,5,0,0,0);
        k(4'hA,5,10,0,0); kv(4'hF,8,8,2,1); k(4'h9,6,8,8,0); k(4'hD,0,0,8,0);
        // Product 4 at qty limit, underpayment, exact payment
        k(4'hF,1,0,0,0); k(4'h4,2,10,0,0); k(4'hF,3,1,0,0); k(4'hB,3,2,0,0); k(4'hB,3,3,0,0);
        k(4'hB,3,3,0,1); k(4'hF,4,30,0,0); k(4'hE,5,0,0,0); k(4'hA,5,10,0,0); k(4'hA,5,20,0,0);
        k(4'h9,5,25,0,0); k(4'hF,5,25,0,1); k(4'h9,5,30,0,0); kv(4'hF,0,0,4,3); k(4'hD,0,0,0,0);
        // Exhaust product 1: qty 3 then qty 1 (limit bounded by remaining stock)
        k(4'hF,1,0,0,0); k(4'h1,2,1,0,0); k(4'hF,3,1,0,0); k(4'hB,3,2,0,0); k(4'hB,3,3,0,0);
        k(4'hF,4,3,0,0); k(4'hE,5,0,0,0); k(4'h8,5,1,0,0); k(4'h8,5,2,0,0); k(4'h8,5,3,0,0);
        kv(4'hF,0,0,1,3); k(4'hD,0,0,0,0);
        k(4'hF,1,0,0,0); k(4'h1,2,1,0,0); k(4'hF,3,1,0,0); k(4'hB,3,1,0,1); k(4'hF,4,1,0,0);
        k(4'hE,5,0,0,0); k(4'h9,5,5,0,0); kv(4'hF,4,4,1,1); k(4'hD,0,0,4,0);
        // Empty product, out-of-range and undefined keys in SELECT
        k(4'hF,1,0,0,0); k(4'h1,1,0,0,1); k(4'h6,1,0,0,1); k(4'h0,1,0,0,1); k(4'hA,1,0,0,1);
        // Remaining stock of product 2 is 3: buy all, then it is empty
        k(4'h2,2,2,0,0); k(4'hF,3,1,0,0); k(4'hB,3,2,0,0); k(4'hB,3,3,0,0); k(4'hB,3,3,0,1);
        k(4'hF,4,6,0,0); k(4'hE,5,0,0,0); k(4'hA,5,10,0,0); kv(4'hF,4,4,2,3); k(4'hD,0,0,4,0);
        k(4'hF,1,0,0,0); k(4'h2,1,0,0,1); k(4'hD,0,0,0,0);
        // Cancel from PRICE; qty- at 1; refund from PAY; undefined key in IDLE
        k(4'hF,1,0,0,0); k(4'h3,2,5,0,0); k(4'hD,0,0,0,0);
        k(4'hF,1,0,0,0); k(4'h3,2,5,0,0); k(4'hF,3,1,0,0); k(4'hC,3,1,0,1); k(4'hF,4,5,0,0);
        k(4'hE,5,0,0,0); k(4'h9,5,5,0,0); k(4'h8,5,6,0,0); k(4'hD,0,0,6,0); k(4'h8,0,0,6,1);
        // Timeout in PAY refunds after 20 idle cycles
        k(4'hF,1,0,0,0); k(4'h3,2,5,0,0); k(4'hF,3,1,0,0); k(4'hF,4,5,0,0); k(4'hE,5,0,0,0);
        k(4'hA,5,10,0,0); idl(19,5,10,0); idl(1,0,0,10);
        // Key on the expiry cycle wins and restarts the count
        k(4'hF,1,0,0,0); k(4'h3,2,5,0,0); k(4'hF,3,1,0,0); k(4'hF,4,5,0,0); k(4'hE,5,0,0,0);
        k(4'hA,5,10,0,0); idl(19,5,10,0); k(4'h8,5,11,0,0); idl(19,5,11,0); idl(1,0,0,11);
        // Timeout in QTY
        k(4'hF,1,0,0,0); k(4'h3,2,5,0,0); k(4'hF,3,1,0,0); idl(19,3,1,0); idl(1,0,0,0);
    endtask

    task automatic compare(input int idx);
        vec_t e;
        logic ok;
        e = exp_q.pop_front();
        checks++;
        ok = (state_code === e.st) && (display_value === e.disp) && (change === e.chg) &&
             (vend === e.vend) && (error === e.err) &&
             (!e.vend || (vend_prod === e.vprod && vend_qty === e.vqty));
        if (!ok) begin
            errors++;
            $display("FAIL step %0d key=%h: got st=%0d disp=%0d chg=%0d vend=%b p=%0d q=%0d err=%b, want st=%0d disp=%0d chg=%0d vend=%b p=%0d q=%0d err=%b",
                     idx, e.key, state_code, display_value, change, vend, vend_prod, vend_qty,
                     error, e.st, e.disp, e.chg, e.vend, e.vprod, e.vqty, e.err);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_q.push_back(v);
        key_valid = v.valid;
        key_code  = v.key;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        compare(idx);
    endtask

    task automatic press4(input logic valid, input logic [3:0] key);
        k4_valid = valid;
        k4_code  = key;
        @(posedge clk);
        #1;
        k4_valid = 1'b0;
        k4_code  = 4'h0;
    endtask

    task automatic chk4(input string name, input logic [2:0] st, input logic [3:0] disp,
                        input logic [3:0] chg, input logic err);
        checks++;
        if (st4 !== st || disp4 !== disp || chg4 !== chg || err4 !== err || vend4 !== 1'b0) begin
            errors++;
            $display("FAIL %s: got st=%0d disp=%0d chg=%0d err=%b vend=%b, want st=%0d disp=%0d chg=%0d err=%b vend=0",
                     name, st4, disp4, chg4, err4, vend4, st, disp, chg, err);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rst4_n = 1'b0;
        key_valid = 1'b0; key_code = 4'h0;
        k4_valid = 1'b0; k4_code = 4'h0;
        build_table();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (state_code !== 3'd0 || display_value !== 8'd0 || change !== 8'd0 || vend !== 1'b0 ||
            vend_prod !== 3'd0 || vend_qty !== 3'd0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset: got st=%0d disp=%0d chg=%0d vend=%b p=%0d q=%0d err=%b, want all 0",
                     state_code, display_value, change, vend, vend_prod, vend_qty, error);
        end
        chk4("reset4", 3'd0, 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; rst4_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Narrow amount register: 15 fits, 16 is refused
        press4(1'b1, 4'hF); chk4("n4_select", 3'd1, 4'd0, 4'd0, 1'b0);
        press4(1'b1, 4'h1); chk4("n4_price", 3'd2, 4'd1, 4'd0, 1'b0);
        press4(1'b1, 4'hF); chk4("n4_qty", 3'd3, 4'd1, 4'd0, 1'b0);
        press4(1'b1, 4'hF); chk4("n4_confirm", 3'd4, 4'd1, 4'd0, 1'b0);
        press4(1'b1, 4'hE); chk4("n4_pay", 3'd5, 4'd0, 4'd0, 1'b0);
        press4(1'b1, 4'hA); chk4("n4_coin10", 3'd5, 4'd10, 4'd0, 1'b0);
        press4(1'b1, 4'h9); chk4("n4_coin5_to15", 3'd5, 4'd15, 4'd0, 1'b0);
        for (int i = 0; i < 30; i++) press4(1'b0, 4'h0);
        chk4("n4_no_timeout", 3'd5, 4'd15, 4'd0, 1'b0);
        press4(1'b1, 4'h8); chk4("n4_overflow", 3'd5, 4'd15, 4'd0, 1'b1);
        #2;
        rst4_n = 1'b0;
        #1;
        checks++;
        if (st4 !== 3'd0 || disp4 !== 4'd0 || chg4 !== 4'd0 || err4 !== 1'b0 ||
            vend4 !== 1'b0 || vp4 !== 3'd0 || vq4 !== 3'd0) begin
            errors++;
            $display("FAIL n4_async_reset: got st=%0d disp=%0d chg=%0d err=%b vend=%b p=%0d q=%0d, want all 0",
                     st4, disp4, chg4, err4, vend4, vp4, vq4);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
